// File: rtl/booth_dot_accumulator_pkg.sv
// Shared definitions for the Booth dot-product accumulator: operand/product
// widths and the frame control state encoding.
package booth_dot_accumulator_pkg;

  localparam int OPW   = 8;
  localparam int PRODW = 16;

  typedef enum logic [1:0] {
    ST_ACC   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

endpackage

// File: rtl/boothmultiplier.sv
// Combinational 8x8 signed radix-4 Booth multiplier; i_a is recoded,
// i_b is the multiplicand.
module boothmultiplier
  import booth_dot_accumulator_pkg::*;
(
  input  logic signed [OPW-1:0]   i_a,
  input  logic signed [OPW-1:0]   i_b,
  output logic signed [PRODW-1:0] o_prod
);

  logic        [OPW:0]       w_rec;
  logic signed [PRODW-1:0]   w_mcand;
  logic signed [PRODW-1:0]   w_pp;
  logic signed [PRODW-1:0]   w_sum;

  // Implicit zero below the LSB starts the overlapping 3-bit recoding windows.
  assign w_rec   = {i_a, 1'b0};
  assign w_mcand = {{(PRODW-OPW){i_b[OPW-1]}}, i_b};

  always_comb begin
    w_sum = '0;
    w_pp  = '0;
    for (int i = 0; i < OPW/2; i++) begin
      case (w_rec[2*i +: 3])
        3'b001, 3'b010: w_pp = w_mcand;
        3'b011:         w_pp = w_mcand <<< 1;
        3'b100:         w_pp = -(w_mcand <<< 1);
        3'b101, 3'b110: w_pp = -w_mcand;
        default:        w_pp = '0;
      endcase
      w_sum = w_sum + (w_pp <<< (2*i));
    end
  end

  assign o_prod = w_sum;

endmodule

// File: rtl/booth_dot_accumulator.sv
// Streams signed operand pairs through one Booth multiplier and sums LEN
// products per frame into a saturating or wrapping dot-product result.
module booth_dot_accumulator
  import booth_dot_accumulator_pkg::*;
#(
  parameter int LEN   = 8,
  parameter int ACC_W = 20,
  parameter int SAT   = 1
)(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [OPW-1:0]   in_a,
  input  logic signed [OPW-1:0]   in_b,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [ACC_W-1:0] out_data,
  output logic                    out_ovf
);

  localparam int               CNT_W = $clog2(LEN + 1);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(LEN - 1);

  state_t r_state, w_state_nxt;

  logic signed [OPW-1:0]   r_a_p0, r_b_p0;
  logic                    r_vld_p0;
  logic [CNT_W-1:0]        r_cnt;
  logic signed [ACC_W-1:0] r_acc_p1;
  logic                    r_ovf_p1;
  logic signed [ACC_W-1:0] r_out_data;
  logic                    r_out_ovf;
  logic                    r_out_valid;

  logic                    w_in_ready;
  logic                    w_accept;
  logic signed [PRODW-1:0] w_prod;
  logic signed [ACC_W:0]   w_sum;
  logic                    w_event;
  logic signed [ACC_W-1:0] w_acc_nxt;

  function automatic logic signed [ACC_W:0] sext_prod(input logic signed [PRODW-1:0] p);
    return {{(ACC_W+1-PRODW){p[PRODW-1]}}, p};
  endfunction

  function automatic logic out_of_range(input logic signed [ACC_W:0] s);
    return s[ACC_W] ^ s[ACC_W-1];
  endfunction

  function automatic logic signed [ACC_W-1:0] sat_or_wrap(input logic signed [ACC_W:0] s);
    logic signed [ACC_W-1:0] v;
    v = s[ACC_W-1:0];
    if ((SAT != 0) && out_of_range(s))
      v = s[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    return v;
  endfunction

  boothmultiplier u_mult (
    .i_a    (r_a_p0),
    .i_b    (r_b_p0),
    .o_prod (w_prod)
  );

  assign w_sum     = {r_acc_p1[ACC_W-1], r_acc_p1} + sext_prod(w_prod);
  assign w_event   = out_of_range(w_sum);
  assign w_acc_nxt = sat_or_wrap(w_sum);
  assign w_accept  = in_valid & w_in_ready & ~clr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_ACC;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    case (r_state)
      ST_ACC: begin
        w_in_ready = 1'b1;
        if (in_valid && (r_cnt == LAST)) w_state_nxt = ST_FLUSH;
      end
      ST_FLUSH: w_state_nxt = ST_HOLD;
      ST_HOLD:  if (out_ready) w_state_nxt = ST_ACC;
      default:  w_state_nxt = ST_ACC;
    endcase
    if (clr) w_state_nxt = ST_ACC;
  end

  // Stage p0: operand capture; stage p1: product accumulation and frame close.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_p0      <= '0;
      r_b_p0      <= '0;
      r_vld_p0    <= 1'b0;
      r_cnt       <= '0;
      r_acc_p1    <= '0;
      r_ovf_p1    <= 1'b0;
      r_out_data  <= '0;
      r_out_ovf   <= 1'b0;
      r_out_valid <= 1'b0;
    end else if (clr) begin
      r_vld_p0    <= 1'b0;
      r_cnt       <= '0;
      r_acc_p1    <= '0;
      r_ovf_p1    <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_vld_p0 <= w_accept;
      if (w_accept) begin
        r_a_p0 <= in_a;
        r_b_p0 <= in_b;
        r_cnt  <= r_cnt + 1'b1;
      end
      if (r_state == ST_FLUSH) begin
        r_out_data  <= w_acc_nxt;
        r_out_ovf   <= r_ovf_p1 | w_event;
        r_out_valid <= 1'b1;
        r_acc_p1    <= '0;
        r_ovf_p1    <= 1'b0;
        r_cnt       <= '0;
      end else if (r_vld_p0) begin
        r_acc_p1 <= w_acc_nxt;
        r_ovf_p1 <= r_ovf_p1 | w_event;
      end
      if ((r_state == ST_HOLD) && out_ready) r_out_valid <= 1'b0;
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_ovf   = r_out_ovf;

endmodule
